hub75_row_shifter: RTL and testbench

HUB75_ROW_SHIFTER -- requirements
Module: hub75_row_shifter

---
 rtl/hub75_row_shifter_if.sv | 41 ++++
 rtl/hub75_row_shifter.sv | 152 +++++++++++++++
 tb/tb_hub75_row_shifter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hub75_row_shifter_if.sv
// Control, line-buffer read and PHY signals of the HUB75 row shifter, bundled
// so the controller side (master) and the shifter (slave) share one port.
interface hub75_row_shifter_if #(
    parameter int N_BANKS  = 2,
    parameter int N_ROWS   = 32,
    parameter int N_COLS   = 64,
    parameter int N_CHANS  = 3,
    parameter int BITDEPTH = 8
);
    localparam int LOG_N_ROWS = $clog2(N_ROWS);
    localparam int LOG_N_COLS = $clog2(N_COLS);
    localparam int LOG_BD     = $clog2(BITDEPTH);
    localparam int SDW        = N_BANKS * N_CHANS;

    logic                    ctrl_go;
    logic [LOG_N_ROWS-1:0]   ctrl_row;
    logic [LOG_BD-1:0]       ctrl_plane;
    logic                    ctrl_rdy;

    logic [LOG_N_COLS-1:0]   buf_rd_addr;
    logic                    buf_rd_en;
    logic [SDW*BITDEPTH-1:0] buf_rd_data;

    logic [LOG_N_ROWS-1:0]   phy_addr;
    logic [SDW-1:0]          phy_data;
    logic                    phy_clk;
    logic                    phy_le;
    logic                    phy_blank;

    modport master (
        output ctrl_go, ctrl_row, ctrl_plane, buf_rd_data,
        input  ctrl_rdy, buf_rd_addr, buf_rd_en,
               phy_addr, phy_data, phy_clk, phy_le, phy_blank
    );

    modport slave (
        input  ctrl_go, ctrl_row, ctrl_plane, buf_rd_data,
        output ctrl_rdy, buf_rd_addr, buf_rd_en,
               phy_addr, phy_data, phy_clk, phy_le, phy_blank
    );
endinterface

// File: rtl/hub75_row_shifter.sv
// Shifts one bit plane of one line out to a HUB75 panel, then blanks and latches.
// Optional macro HUB75_ROW_SHIFTER_REVERSE_EN reads columns N_COLS-1 down to 0.
module hub75_row_shifter #(
    parameter int N_BANKS      = 2,
    parameter int N_ROWS       = 32,
    parameter int N_COLS       = 64,
    parameter int N_CHANS      = 3,
    parameter int BITDEPTH     = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    hub75_row_shifter_if.slave     bus
);
    localparam int LOG_N_ROWS = $clog2(N_ROWS);
    localparam int LOG_N_COLS = $clog2(N_COLS);
    localparam int LOG_BD     = $clog2(BITDEPTH);
    localparam int SDW        = N_BANKS * N_CHANS;

    localparam logic [LOG_N_COLS-1:0] LAST_COL  = LOG_N_COLS'(N_COLS - 1);
    localparam logic [7:0]            LAST_BLNK = 8'(BLANK_CYCLES - 1);
    localparam logic [LOG_BD:0]       BD_LIMIT  = (LOG_BD + 1)'(BITDEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_FLUSH,
        S_BLANK,
        S_LATCH
    } state_t;

    state_t                r_state;
    logic [LOG_N_COLS-1:0] r_col;
    logic [7:0]            r_cnt;
    logic [LOG_N_ROWS-1:0] r_row;
    logic [LOG_BD-1:0]     r_plane;
    logic                  r_rdy;
    logic                  r_rd_en;
    logic [LOG_N_COLS-1:0] r_rd_addr;
    logic                  r_rd_vld;
    logic [LOG_N_ROWS-1:0] r_phy_addr;
    logic [SDW-1:0]        r_phy_data;
    logic                  r_phy_clk;
    logic                  r_phy_le;
    logic                  r_phy_blank;

    logic                  w_plane_ok;
    logic [SDW-1:0]        w_plane_bits;

    function automatic logic [LOG_N_COLS-1:0] col_to_addr(input logic [LOG_N_COLS-1:0] col);
`ifdef HUB75_ROW_SHIFTER_REVERSE_EN
        return LAST_COL - col;
`else
        return col;
`endif
    endfunction

    // Out-of-range planes select nothing, so the line shifts out as zeros.
    assign w_plane_ok = ({1'b0, r_plane} < BD_LIMIT);

    for (genvar gi = 0; gi < SDW; gi++) begin : g_plane
        logic [BITDEPTH-1:0] w_chan;
        assign w_chan           = bus.buf_rd_data[gi*BITDEPTH +: BITDEPTH];
        assign w_plane_bits[gi] = w_plane_ok & w_chan[r_plane];
    end

    // NOTE: reset is synchronous; every register, including the data pipeline,
    // is cleared so an interrupted line leaves nothing in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_cnt       <= '0;
            r_row       <= '0;
            r_plane     <= '0;
            r_rdy       <= 1'b1;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_vld    <= 1'b0;
            r_phy_addr  <= '0;
            r_phy_data  <= '0;
            r_phy_clk   <= 1'b0;
            r_phy_le    <= 1'b0;
            r_phy_blank <= 1'b1;
        end else begin
            // Read data arrives one cycle after the strobe and is registered once more.
            r_rd_vld   <= r_rd_en;
            r_phy_clk  <= r_rd_vld;
            r_phy_data <= r_rd_vld ? w_plane_bits : '0;
            r_phy_le   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_phy_blank <= 1'b0;
                    r_rdy       <= 1'b1;
                    if (bus.ctrl_go) begin
                        r_row     <= bus.ctrl_row;
                        r_plane   <= bus.ctrl_plane;
                        r_col     <= '0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= col_to_addr('0);
                        r_rdy     <= 1'b0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_col == LAST_COL) begin
                        r_rd_en <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_FLUSH;
                    end else begin
                        r_col     <= r_col + 1'b1;
                        r_rd_addr <= col_to_addr(r_col + 1'b1);
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == 8'd1) begin
                        r_cnt       <= '0;
                        r_phy_blank <= 1'b1;
                        r_state     <= S_BLANK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BLANK: begin
                    if (r_cnt == LAST_BLNK) begin
                        r_phy_le   <= 1'b1;
                        r_phy_addr <= r_row;
                        r_state    <= S_LATCH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    r_phy_blank <= 1'b0;
                    r_rdy       <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ctrl_rdy    = r_rdy;
    assign bus.buf_rd_en   = r_rd_en;
    assign bus.buf_rd_addr = r_rd_addr;
    assign bus.phy_addr    = r_phy_addr;
    assign bus.phy_data    = r_phy_data;
    assign bus.phy_clk     = r_phy_clk;
    assign bus.phy_le      = r_phy_le;
    assign bus.phy_blank   = r_phy_blank;
endmodule

// File: tb/tb_hub75_row_shifter.sv
// Directed bench for hub75_row_shifter: per-cycle line timing, plane select,
// blanking/latch, back-to-back lines, ignored requests and mid-line reset.
module tb_hub75_row_shifter;
    localparam int N_BANKS      = 2;
    localparam int N_ROWS       = 32;
    localparam int N_COLS       = 64;
    localparam int N_CHANS      = 3;
    localparam int BITDEPTH     = 8;
    localparam int BLANK_CYCLES = 4;
    localparam int SDW          = N_BANKS * N_CHANS;
    localparam int DW           = SDW * BITDEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hub75_row_shifter_if #(
        .N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
        .N_CHANS(N_CHANS), .BITDEPTH(BITDEPTH)
    ) bus ();

    hub75_row_shifter #(
        .N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
        .N_CHANS(N_CHANS), .BITDEPTH(BITDEPTH), .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         errors = 0;
    int         checks = 0;
    int         mode   = 0;
    logic [4:0] exp_paddr = '0;

    // Buffer contents: 0 = column replicated, 1 = all 0x80, 2 = column*(chan+1).
    function automatic logic [DW-1:0] pattern(input int m, input logic [5:0] a);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < SDW; i++) begin
            case (m)
                0:       w[i*8 +: 8] = {2'b00, a};
                1:       w[i*8 +: 8] = 8'h80;
                default: w[i*8 +: 8] = 8'(int'(a) * (i + 1));
            endcase
        end
        return w;
    endfunction

    function automatic logic [5:0] exp_addr(input int col);
`ifdef HUB75_ROW_SHIFTER_REVERSE_EN
        return 6'(N_COLS - 1 - col);
`else
        return 6'(col);
`endif
    endfunction

    function automatic logic [SDW-1:0] exp_bits(input int m, input int col, input int plane);
        logic [DW-1:0]  p;
        logic [SDW-1:0] b;
        p = pattern(m, exp_addr(col));
        b = '0;
        for (int i = 0; i < SDW; i++)
            if (plane < BITDEPTH) b[i] = p[i*BITDEPTH + plane];
        return b;
    endfunction

    // Synchronous line-buffer model; unread cycles return all ones.
    always @(posedge clk) begin
        if (bus.buf_rd_en) bus.buf_rd_data <= pattern(mode, bus.buf_rd_addr);
        else               bus.buf_rd_data <= '1;
    end

    // Drives one line and compares every output on every cycle E0..E0+71.
    task automatic run_line(input string tag, input logic [4:0] row, input logic [2:0] plane,
                            input int m, input bit hold, input int go_k, input int abort_k);
        logic [21:0] obs, exp;
        logic [5:0]  obs_addr;
        int          pulses;
        pulses = 0;
        mode = m;
        bus.ctrl_row   = row;
        bus.ctrl_plane = plane;
        bus.ctrl_go    = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 72; k++) begin
            @(negedge clk);
            obs_addr = (k < N_COLS) ? bus.buf_rd_addr : 6'd0;
            obs = {bus.buf_rd_en, obs_addr, bus.phy_clk, bus.phy_data,
                   bus.phy_blank, bus.phy_le, bus.ctrl_rdy, bus.phy_addr};
            exp = {(k < N_COLS),
                   (k < N_COLS) ? exp_addr(k) : 6'd0,
                   (k >= 2 && k <= N_COLS + 1),
                   (k >= 2 && k <= N_COLS + 1) ? exp_bits(m, k - 2, int'(plane)) : 6'd0,
                   (k >= N_COLS + 2 && k <= N_COLS + 2 + BLANK_CYCLES),
                   (k == N_COLS + 2 + BLANK_CYCLES),
                   (k == 71),
                   (k >= N_COLS + 2 + BLANK_CYCLES) ? row : exp_paddr};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s cycle E0+%0d outputs got=%h expected=%h", tag, k, obs, exp);
            end
            if (bus.phy_clk === 1'b1) pulses++;
            if (k == abort_k) return;
            if (k == 0 && !hold) bus.ctrl_go = 1'b0;
            if (k == go_k) begin
                bus.ctrl_row   = 5'd3;
                bus.ctrl_plane = 3'd7;
                bus.ctrl_go    = 1'b1;
            end
            if (k == go_k + 1) bus.ctrl_go = 1'b0;
        end
        checks++;
        if (pulses !== N_COLS) begin
            errors++;
            $display("FAIL %s phy_clk pulse count got=%0d expected=%0d", tag, pulses, N_COLS);
        end
        exp_paddr = row;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        bus.ctrl_go = 1'b0; bus.ctrl_row = '0; bus.ctrl_plane = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = {bus.buf_rd_en, bus.buf_rd_addr, bus.phy_clk, bus.phy_data,
               bus.phy_blank, bus.phy_le, bus.ctrl_rdy, bus.phy_addr};
        checks++;
        if (obs !== {1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL reset_values got=%h expected=%h", obs, {1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 5'd0});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.phy_blank, bus.ctrl_rdy, bus.buf_rd_en} !== 3'b010) begin
            errors++;
            $display("FAIL post_reset_idle blank/rdy/rd_en got=%b expected=010",
                     {bus.phy_blank, bus.ctrl_rdy, bus.buf_rd_en});
        end
        exp_paddr = '0;
    endtask

    task automatic test_line();
        run_line("line_r5_p3", 5'd5, 3'd3, 0, 1'b0, -10, -1);
    endtask

    task automatic test_planes();
        run_line("plane7_0x80", 5'd6, 3'd7, 1, 1'b0, -10, -1);
        run_line("plane0_0x80", 5'd7, 3'd0, 1, 1'b0, -10, -1);
    endtask

    task automatic test_go_in_blank();
        run_line("go_in_blank", 5'd9, 3'd1, 2, 1'b0, N_COLS + 2, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.buf_rd_en, bus.ctrl_rdy, bus.phy_addr} !== {1'b0, 1'b1, 5'd9}) begin
                errors++;
                $display("FAIL go_in_blank_stays_idle en/rdy/addr got=%b expected=%b",
                         {bus.buf_rd_en, bus.ctrl_rdy, bus.phy_addr}, {1'b0, 1'b1, 5'd9});
            end
        end
    endtask

    task automatic test_back_to_back();
        run_line("b2b_first",  5'd17, 3'd4, 2, 1'b1, -10, -1);
        run_line("b2b_second", 5'd30, 3'd5, 0, 1'b0, -10, -1);
    endtask

    task automatic test_reset_mid_line();
        logic [21:0] obs;
        run_line("mid_reset_line", 5'd12, 3'd2, 0, 1'b0, -10, 20);
        bus.ctrl_go = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        obs = {bus.buf_rd_en, bus.buf_rd_addr, bus.phy_clk, bus.phy_data,
               bus.phy_blank, bus.phy_le, bus.ctrl_rdy, bus.phy_addr};
        checks++;
        if (obs !== {1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL mid_reset_values got=%h expected=%h", obs, {1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 5'd0});
        end
        rst = 1'b0;
        exp_paddr = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.phy_le, bus.buf_rd_en, bus.ctrl_rdy, bus.phy_addr} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
                errors++;
                $display("FAIL mid_reset_no_latch le/en/rdy/addr got=%b expected=%b",
                         {bus.phy_le, bus.buf_rd_en, bus.ctrl_rdy, bus.phy_addr}, {1'b0, 1'b0, 1'b1, 5'd0});
            end
        end
        run_line("after_reset_line", 5'd2, 3'd2, 2, 1'b0, -10, -1);
    endtask

    initial begin
        test_reset();
        test_line();
        test_planes();
        test_go_in_blank();
        test_back_to_back();
        test_reset_mid_line();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
